// File: rtl/udma_i2c_txn_seq.sv
// I2C transaction sequencer: expands one high-level request into the uDMA I2C
// command byte stream, merging write payload bytes from a separate stream.
module udma_i2c_txn_seq #(
  parameter int unsigned WLEN_W  = 8,
  parameter int unsigned RPT_MIN = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [6:0]        req_addr_i,
  input  logic [WLEN_W-1:0] req_wlen_i,
  input  logic [7:0]        req_rlen_i,
  input  logic              req_cfg_i,
  input  logic [15:0]       req_div_i,
  input  logic [7:0]        wdata_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  output logic [7:0]        cmd_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o
);

  localparam logic [7:0] CMD_CFG     = 8'hE0;
  localparam logic [7:0] CMD_START   = 8'h00;
  localparam logic [7:0] CMD_STOP    = 8'h20;
  localparam logic [7:0] CMD_RD_ACK  = 8'h40;
  localparam logic [7:0] CMD_RD_NACK = 8'h60;
  localparam logic [7:0] CMD_WR      = 8'h80;
  localparam logic [7:0] CMD_RPT     = 8'hC0;

  localparam logic [7:0]        RPT_MIN_B = 8'(RPT_MIN);
  localparam logic [WLEN_W-1:0] W_ONE     = WLEN_W'(1);

  typedef enum logic [4:0] {
    S_IDLE, S_CFG0, S_CFG1, S_CFG2, S_START, S_AWC, S_AW, S_WC, S_WD,
    S_RS, S_RWC, S_RA, S_RPTC, S_RPTN, S_RDA, S_RDN, S_STOP, S_DONE
  } state_t;

  state_t            r_state;
  logic [6:0]        r_addr;
  logic [7:0]        r_rlen;
  logic [15:0]       r_div;
  logic [WLEN_W-1:0] r_wcnt;
  logic [7:0]        r_rcnt;
  logic              r_abort;
  logic [7:0]        r_cmd;
  logic              r_cmd_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic              w_fire;
  logic              w_abort;
  logic [7:0]        w_rd_n;
  state_t            w_rd_entry;
  state_t            w_nxt;
  logic [7:0]        w_nxt_byte;

  // Payload bytes bypass the output register so a WD beat costs no extra cycle.
  assign cmd_o         = (r_state == S_WD) ? wdata_i       : r_cmd;
  assign cmd_valid_o   = (r_state == S_WD) ? wdata_valid_i : r_cmd_valid;
  assign wdata_ready_o = (r_state == S_WD) & cmd_ready_i;
  assign req_ready_o   = (r_state == S_IDLE);
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign aborted_o     = r_aborted;

  assign w_fire  = cmd_valid_o & cmd_ready_i;
  assign w_abort = r_abort | abort_i;
  assign w_rd_n  = r_rlen - 8'd1;

  always_comb begin
    w_rd_entry = S_RDN;
    if (w_rd_n >= RPT_MIN_B)   w_rd_entry = S_RPTC;
    else if (w_rd_n != 8'd0)   w_rd_entry = S_RDA;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_CFG0:  w_nxt = S_CFG1;
      S_CFG1:  w_nxt = S_CFG2;
      S_CFG2:  w_nxt = S_START;
      S_START: w_nxt = S_AWC;
      S_AWC:   w_nxt = S_AW;
      S_AW:    w_nxt = (r_wcnt != '0) ? S_WC : ((r_rlen != 8'd0) ? w_rd_entry : S_STOP);
      S_WC:    w_nxt = S_WD;
      S_WD:    w_nxt = (r_wcnt > W_ONE) ? S_WC : ((r_rlen != 8'd0) ? S_RS : S_STOP);
      S_RS:    w_nxt = S_RWC;
      S_RWC:   w_nxt = S_RA;
      S_RA:    w_nxt = w_rd_entry;
      S_RPTC:  w_nxt = S_RPTN;
      S_RPTN:  w_nxt = S_RDA;
      S_RDA:   w_nxt = (r_rcnt > 8'd1) ? S_RDA : S_RDN;
      S_RDN:   w_nxt = S_STOP;
      S_STOP:  w_nxt = S_DONE;
      default: w_nxt = r_state;
    endcase
    // Before START reaches the bus there is nothing to close, so skip STOP.
    if (w_abort) begin
      if (r_state inside {S_CFG0, S_CFG1, S_CFG2, S_START}) w_nxt = S_DONE;
      else if (r_state != S_STOP)                          w_nxt = S_STOP;
    end
  end

  always_comb begin
    w_nxt_byte = 8'h00;
    case (w_nxt)
      S_CFG0:               w_nxt_byte = CMD_CFG;
      S_CFG1:               w_nxt_byte = r_div[15:8];
      S_CFG2:               w_nxt_byte = r_div[7:0];
      S_START, S_RS:        w_nxt_byte = CMD_START;
      S_AWC, S_WC, S_RWC:   w_nxt_byte = CMD_WR;
      S_AW:                 w_nxt_byte = {r_addr, (r_wcnt == '0) && (r_rlen != 8'd0)};
      S_RA:                 w_nxt_byte = {r_addr, 1'b1};
      S_RPTC:               w_nxt_byte = CMD_RPT;
      S_RPTN:               w_nxt_byte = w_rd_n;
      S_RDA:                w_nxt_byte = CMD_RD_ACK;
      S_RDN:                w_nxt_byte = CMD_RD_NACK;
      S_STOP:               w_nxt_byte = CMD_STOP;
      default:              w_nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rlen      <= '0;
      r_div       <= '0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_abort     <= 1'b0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (r_busy && abort_i) r_abort <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_addr      <= req_addr_i;
            r_wcnt      <= req_wlen_i;
            r_rlen      <= req_rlen_i;
            r_div       <= req_div_i;
            r_state     <= req_cfg_i ? S_CFG0 : S_START;
            r_cmd       <= req_cfg_i ? CMD_CFG : CMD_START;
            r_cmd_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_abort     <= 1'b0;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          if (w_fire) begin
            r_state     <= w_nxt;
            r_cmd       <= w_nxt_byte;
            r_cmd_valid <= !(w_nxt inside {S_WD, S_DONE});
            if (r_state == S_WD)  r_wcnt <= r_wcnt - W_ONE;
            if (r_state == S_RDA) r_rcnt <= r_rcnt - 8'd1;
            if (w_nxt == S_RDA && r_state != S_RDA)
              r_rcnt <= (r_state == S_RPTN) ? 8'd1 : w_rd_n;
            if (w_nxt == S_DONE) begin
              r_done    <= 1'b1;
              r_aborted <= w_abort;
              r_busy    <= 1'b0;
              r_abort   <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udma_i2c_txn_seq.sv
// Bench for udma_i2c_txn_seq: directed stream checks plus randomized requests
// against a byte-list reference model with backpressure and abort injection.
module tb_udma_i2c_txn_seq;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic [6:0]  req_addr;
  logic [7:0]  req_wlen;
  logic [7:0]  req_rlen;
  logic        req_cfg;
  logic [15:0] req_div;
  logic [7:0]  wdata;
  logic        wdata_valid;
  logic        wdata_ready_o;
  logic [7:0]  cmd_o;
  logic        cmd_valid_o;
  logic        cmd_ready;
  logic        abort_in;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;

  int n_cmp = 0;
  int n_err = 0;

  udma_i2c_txn_seq #(.WLEN_W(8), .RPT_MIN(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr), .req_wlen_i(req_wlen), .req_rlen_i(req_rlen),
    .req_cfg_i(req_cfg), .req_div_i(req_div),
    .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready_o),
    .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready),
    .abort_i(abort_in), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected stream built from the transaction description; abort_k is the
  // index of the beat during which abort is raised (-1: none).
  function automatic byte_q_t model(input logic [6:0] addr, input int wlen, input int rlen,
                                    input logic cfg, input logic [15:0] div,
                                    input byte_q_t pay, input int abort_k);
    byte_q_t q;
    byte_q_t t;
    int      start_idx;
    int      n;
    logic    rnw;
    q = {};
    if (cfg) begin
      q.push_back(8'hE0); q.push_back(div[15:8]); q.push_back(div[7:0]);
    end
    start_idx = q.size();
    rnw = (wlen == 0) && (rlen > 0);
    q.push_back(8'h00); q.push_back(8'h80); q.push_back({addr, rnw});
    for (int i = 0; i < wlen; i++) begin
      q.push_back(8'h80); q.push_back(pay[i]);
    end
    if (wlen > 0 && rlen > 0) begin
      q.push_back(8'h00); q.push_back(8'h80); q.push_back({addr, 1'b1});
    end
    if (rlen > 0) begin
      n = rlen - 1;
      if (n >= 2) begin
        q.push_back(8'hC0); q.push_back(8'(n)); q.push_back(8'h40);
      end else begin
        for (int i = 0; i < n; i++) q.push_back(8'h40);
      end
      q.push_back(8'h60);
    end
    q.push_back(8'h20);
    if (abort_k < 0 || abort_k >= q.size()) return q;
    t = {};
    for (int i = 0; i <= abort_k; i++) t.push_back(q[i]);
    if (abort_k > start_idx && abort_k != q.size() - 1) t.push_back(8'h20);
    return t;
  endfunction

  task automatic run_txn(input string name, input logic [6:0] addr, input int wlen,
                         input int rlen, input logic cfg, input logic [15:0] div,
                         input byte_q_t pay, input int abort_k, input bit bp,
                         input byte_q_t exp, input bit exp_ab);
    byte_q_t    got;
    int         pidx = 0;
    bit         hold = 0;
    bit         prev_pend = 0;
    logic [7:0] prev_cmd = 8'h00;
    bit         ab_sent = 0;
    bit         done = 0;
    bit         first = 1;
    int         nmin;
    got = {};
    @(negedge clk);
    #1;
    chk({name, " req_ready idle"}, req_ready_o, 1);
    req_valid = 1; req_addr = addr; req_wlen = wlen[7:0]; req_rlen = rlen[7:0];
    req_cfg = cfg; req_div = div; wdata_valid = 0; cmd_ready = 0; abort_in = 0;
    @(negedge clk);
    req_valid = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      abort_in = 0;
      cmd_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!hold) begin
        wdata_valid = (pidx < wlen) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
        wdata = (pidx < wlen) ? pay[pidx] : 8'h00;
      end
      #1;
      if (first) chk({name, " first cmd_valid"}, cmd_valid_o, 1);
      first = 0;
      chk({name, " req_ready busy"}, req_ready_o, 0);
      if (prev_pend) begin
        chk({name, " valid held"}, cmd_valid_o, 1);
        chk({name, " cmd stable"}, cmd_o, prev_cmd);
      end
      if (done_o) begin
        chk({name, " aborted_o"}, aborted_o, exp_ab);
        chk({name, " busy at done"}, busy_o, 0);
        done = 1;
      end else if (cmd_valid_o) begin
        if (abort_k == got.size() && !ab_sent) begin
          abort_in = 1; ab_sent = 1;
        end
        if (cmd_ready) got.push_back(cmd_o);
      end
      prev_pend = cmd_valid_o && !cmd_ready;
      prev_cmd  = cmd_o;
      if (wdata_valid && wdata_ready_o) pidx++;
      hold = wdata_valid && !wdata_ready_o;
      @(negedge clk);
    end
    abort_in = 0; wdata_valid = 0;
    chk({name, " done seen"}, done, 1);
    #1;
    chk({name, " done one cycle"}, done_o, 0);
    chk({name, " req_ready after"}, req_ready_o, 1);
    chk({name, " stream length"}, got.size(), exp.size());
    nmin = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < nmin; i++)
      chk($sformatf("%s byte%0d", name, i), got[i], exp[i]);
  endtask

  initial begin
    byte_q_t e;
    byte_q_t p;
    byte_q_t full;
    logic [6:0]  ra;
    logic [15:0] rd;
    logic        rc;
    int          rw, rr, rk;

    rst = 1; req_valid = 0; req_addr = 0; req_wlen = 0; req_rlen = 0; req_cfg = 0;
    req_div = 0; wdata = 0; wdata_valid = 0; cmd_ready = 0; abort_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst cmd_valid", cmd_valid_o, 0);
    chk("rst req_ready", req_ready_o, 1);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst aborted", aborted_o, 0);
    chk("rst wdata_ready", wdata_ready_o, 0);
    chk("rst cmd", cmd_o, 8'h00);
    @(negedge clk);
    rst = 0;

    p = '{8'h11, 8'h22};
    e = '{8'h00, 8'h80, 8'hA0, 8'h80, 8'h11, 8'h80, 8'h22, 8'h20};
    run_txn("write", 7'h50, 2, 0, 0, 16'h0, p, -1, 0, e, 0);
    run_txn("write_bp", 7'h50, 2, 0, 0, 16'h0, p, -1, 1, e, 0);

    p = {};
    e = '{8'h00, 8'h80, 8'hA1, 8'hC0, 8'h03, 8'h40, 8'h60, 8'h20};
    run_txn("read4", 7'h50, 0, 4, 0, 16'h0, p, -1, 0, e, 0);
    e = '{8'h00, 8'h80, 8'hA1, 8'h40, 8'h60, 8'h20};
    run_txn("read2", 7'h50, 0, 2, 0, 16'h0, p, -1, 0, e, 0);
    e = '{8'h00, 8'h80, 8'hA1, 8'h60, 8'h20};
    run_txn("read1", 7'h50, 0, 1, 0, 16'h0, p, -1, 0, e, 0);
    e = '{8'h00, 8'h80, 8'hA1, 8'hC0, 8'hFE, 8'h40, 8'h60, 8'h20};
    run_txn("read255", 7'h50, 0, 255, 0, 16'h0, p, -1, 0, e, 0);
    e = '{8'h00, 8'h80, 8'hA0, 8'h20};
    run_txn("probe", 7'h50, 0, 0, 0, 16'h0, p, -1, 0, e, 0);

    p = '{8'h05};
    e = '{8'hE0, 8'h01, 8'h23, 8'h00, 8'h80, 8'hA0, 8'h80, 8'h05,
          8'h00, 8'h80, 8'hA1, 8'h60, 8'h20};
    run_txn("combined", 7'h50, 1, 1, 1, 16'h0123, p, -1, 0, e, 0);

    p = '{8'h11, 8'h33, 8'h44};
    e = '{8'h00, 8'h80, 8'hA0, 8'h80, 8'h11, 8'h20};
    run_txn("abort_wd", 7'h50, 3, 0, 0, 16'h0, p, 4, 0, e, 1);
    p = {};
    e = '{8'hE0, 8'h01};
    run_txn("abort_cfg1", 7'h50, 0, 1, 1, 16'h0123, p, 1, 0, e, 1);

    // Reset in the middle of a read transaction.
    @(negedge clk);
    req_valid = 1; req_addr = 7'h50; req_wlen = 0; req_rlen = 4; req_cfg = 0; cmd_ready = 1;
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("midread busy", busy_o, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("midrst cmd_valid", cmd_valid_o, 0);
    chk("midrst req_ready", req_ready_o, 1);
    chk("midrst busy", busy_o, 0);
    @(negedge clk);
    rst = 0;

    for (int t = 0; t < 40; t++) begin
      ra = 7'($urandom);
      rw = $urandom_range(0, 4);
      rr = $urandom_range(0, 5);
      if (rr == 5) rr = $urandom_range(0, 255);
      rc = 1'($urandom_range(0, 1));
      rd = 16'($urandom);
      p = {};
      for (int i = 0; i < rw; i++) p.push_back(8'($urandom));
      full = model(ra, rw, rr, rc, rd, p, -1);
      rk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, full.size() - 1)) : -1;
      e = model(ra, rw, rr, rc, rd, p, rk);
      run_txn($sformatf("rand%0d", t), ra, rw, rr, rc, rd, p, rk, 1, e, rk >= 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
